// File: rtl/uart_tx_buffer.sv
// Transmit byte buffer: circular FIFO feeding a UART transmitter via a drain FSM.
// Optional UART_TX_BUFFER_FLUSH_EN adds a synchronous flush input.
module uart_tx_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
`ifdef UART_TX_BUFFER_FLUSH_EN
    input  logic              flush,
`endif
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done_tick,
    output logic              busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   w_ptr, r_ptr;
    logic [ADDR_W:0]     count_next;
    logic                push, pop, flush_i;

`ifdef UART_TX_BUFFER_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Writes are judged against the registered full flag, so a same-edge pop
    // never makes room for a write arriving while full.
    assign push = wr & ~full & ~flush_i;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !flush_i) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: state_next = WAIT;
            WAIT: begin
                if (tx_done_tick)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        if (flush_i)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CNT_ONE;
        else if (pop && !push)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            w_ptr   <= '0;
            r_ptr   <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            ovf     <= 1'b0;
            tx_data <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNT_FULL);
            if (wr && full && !flush_i)
                ovf <= 1'b1;
            if (flush_i) begin
                w_ptr <= '0;
                r_ptr <= '0;
            end else begin
                if (push)
                    w_ptr <= w_ptr + PTR_ONE;
                if (pop) begin
                    r_ptr   <= r_ptr + PTR_ONE;
                    tx_data <= mem[r_ptr];
                end
            end
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push)
            mem[w_ptr] <= w_data;
    end

    assign tx_start = (state == SEND);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: queue-based reference model plus directed checks.
module tb_uart_tx_buffer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              reset;
    logic              wr;
    logic [DATA_W-1:0] w_data;
`ifdef UART_TX_BUFFER_FLUSH_EN
    logic              flush;
`endif
    logic              full, empty, ovf, tx_start, busy;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] tx_data;
    logic              tx_done_tick;

    uart_tx_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .w_data       (w_data),
`ifdef UART_TX_BUFFER_FLUSH_EN
        .flush        (flush),
`endif
        .full         (full),
        .empty        (empty),
        .count        (count),
        .ovf          (ovf),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds bytes waiting; a handed-off byte is
    // "in flight" until the transmitter reports done, and its start pulse is
    // due in the cycle right after the hand-off.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_data;
    bit                m_ovf, m_inflight, m_start_due;

    always @(posedge clk or posedge reset) begin : model
        bit take, done_ok, was_full, fl;
        if (reset) begin
            q.delete();
            m_data      = '0;
            m_ovf       = 1'b0;
            m_inflight  = 1'b0;
            m_start_due = 1'b0;
        end else begin
            fl = 1'b0;
`ifdef UART_TX_BUFFER_FLUSH_EN
            fl = flush;
`endif
            was_full = (q.size() == DEPTH);
            take     = !m_inflight && (q.size() != 0) && !fl;
            done_ok  = m_inflight && !m_start_due && tx_done_tick;
            if (take)
                m_data = q.pop_front();
            if (fl)
                q.delete();
            else if (wr) begin
                if (was_full) m_ovf = 1'b1;
                else          q.push_back(w_data);
            end
            m_start_due = take;
            if (take)         m_inflight = 1'b1;
            else if (done_ok) m_inflight = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count",    32'(count),    32'(q.size()));
            chk("empty",    32'(empty),    32'(q.size() == 0));
            chk("full",     32'(full),     32'(q.size() == DEPTH));
            chk("ovf",      32'(ovf),      32'(m_ovf));
            chk("tx_start", 32'(tx_start), 32'(m_start_due));
            chk("busy",     32'(busy),     32'(m_inflight));
            chk("tx_data",  32'(tx_data),  32'(m_data));
        end
    end

    logic [DATA_W-1:0] cap[$];

    task automatic step();
        @(posedge clk);
        #1;
        if (tx_start) cap.push_back(tx_data);
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; w_data = '0; tx_done_tick = 1'b0;
`ifdef UART_TX_BUFFER_FLUSH_EN
        flush = 1'b0;
`endif
        step(); step();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_busy",  32'(busy),  0);
        cmp_en = 1'b1;
        reset  = 1'b0;
        step();

        // single byte: start pulse two edges after the write
        wr = 1'b1; w_data = 8'h41;
        step();
        wr = 1'b0;
        chk("t1_count", 32'(count), 1);
        chk("t1_nostart", 32'(tx_start), 0);
        step();
        chk("t1_start", 32'(tx_start), 1);
        chk("t1_data",  32'(tx_data), 32'h41);
        chk("t1_busy",  32'(busy), 1);
        step();
        chk("t1_pulse_end", 32'(tx_start), 0);
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("t1_idle",  32'(busy), 0);
        chk("t1_empty", 32'(empty), 1);

        // fill with transmitter stalled, then overflow
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; w_data = 8'(8'h10 + i);
            step();
        end
        chk("t2_count7", 32'(count), 7);
        chk("t2_notfull", 32'(full), 0);
        chk("t2_first", 32'(tx_data), 32'h10);
        w_data = 8'h18;
        step();
        chk("t2_count8", 32'(count), 8);
        chk("t2_full", 32'(full), 1);
        w_data = 8'h19;
        step();
        wr = 1'b0;
        chk("t2_drop_count", 32'(count), 8);
        chk("t2_ovf", 32'(ovf), 1);

        // async reset while waiting on the transmitter
        reset = 1'b1;
        #1;
        chk("t5_count", 32'(count), 0);
        chk("t5_ovf",   32'(ovf), 0);
        chk("t5_data",  32'(tx_data), 0);
        chk("t5_busy",  32'(busy), 0);
        chk("t5_full",  32'(full), 0);
        step();
        reset = 1'b0;
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("t5_stray_start", 32'(tx_start), 0);
        step();
        chk("t5_stray_start2", 32'(tx_start), 0);

        // paced transmitter, three bytes in order
        cap.delete();
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; w_data = 8'(8'hA0 + i);
            step();
        end
        wr = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tx_done_tick = (c % 10 == 9);
            step();
        end
        tx_done_tick = 1'b0;
        chk("t3_starts", 32'(cap.size()), 3);
        if (cap.size() == 3) begin
            chk("t3_b0", 32'(cap[0]), 32'hA0);
            chk("t3_b1", 32'(cap[1]), 32'hA1);
            chk("t3_b2", 32'(cap[2]), 32'hA2);
        end

`ifdef UART_TX_BUFFER_FLUSH_EN
        for (int i = 0; i < 6; i++) begin
            wr = 1'b1; w_data = 8'(8'hC0 + i);
            step();
        end
        wr = 1'b0;
        chk("t6_count5", 32'(count), 5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_count0", 32'(count), 0);
        chk("t6_empty",  32'(empty), 1);
        chk("t6_hold",   32'(tx_data), 32'hC0);
        chk("t6_busy",   32'(busy), 1);
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        step(); step();
        chk("t6_nostart", 32'(tx_start), 0);
        chk("t6_idle",    32'(busy), 0);
`endif

        // randomized traffic across pointer wraps, bursts and stalls
        for (int i = 0; i < 4000; i++) begin
            int wp;
            wp = ((i / 400) % 3 == 0) ? 80 : (((i / 400) % 3 == 1) ? 45 : 15);
            wr           = ($urandom_range(0, 99) < wp);
            w_data       = 8'($urandom);
            tx_done_tick = ($urandom_range(0, 3) == 0);
            reset        = ($urandom_range(0, 999) == 0);
`ifdef UART_TX_BUFFER_FLUSH_EN
            flush        = ($urandom_range(0, 149) == 0);
`endif
            step();
        end
        reset = 1'b0; wr = 1'b0;
`ifdef UART_TX_BUFFER_FLUSH_EN
        flush = 1'b0;
`endif
        for (int i = 0; i < 60; i++) begin
            tx_done_tick = ($urandom_range(0, 1) == 0);
            step();
        end
        tx_done_tick = 1'b1;
        step(); step(); step();
        chk("final_empty", 32'(empty), 1);
        chk("final_count", 32'(count), 0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
